// File: rtl/fnd_pkg.sv
// rtl/fnd_pkg.sv - shared constants and FSM state type for the FND display scheduler
// Purpose: register offsets of the FND APB slave, display saturation limit and
//          the scheduler's APB master state encoding.
// Ports:   none (package).
package fnd_pkg;

  localparam logic [4:0]  FND_FCR_ADDR = 5'h00;  // control register: bit 0 = display enable
  localparam logic [4:0]  FND_FDR_ADDR = 5'h04;  // data register: value shown on the 4 digits
  localparam int unsigned FND_MAX_VAL  = 9999;   // largest value 4 decimal digits can show

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_ACK    = 2'd3
  } fnd_sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin picker over an eligibility mask
// Purpose: returns the first eligible index found scanning upward from start_i,
//          wrapping past N-1 back to 0.
// Ports:   start_i     - index examined first
//          elig_i      - one bit per candidate, 1 = may be granted
//          gnt_valid_o - some candidate was eligible
//          gnt_idx_o   - index of the chosen candidate (0 when none)
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [IW-1:0] start_i,
  input  logic [N-1:0]  elig_i,
  output logic          gnt_valid_o,
  output logic [IW-1:0] gnt_idx_o
);

  logic [IW:0]   sum;
  logic [IW-1:0] idx;

  // Scan from the farthest position back to start_i so the closest eligible
  // candidate is the last one written and therefore wins.
  always_comb begin
    gnt_valid_o = 1'b0;
    gnt_idx_o   = '0;
    sum         = '0;
    idx         = '0;
    for (int k = N - 1; k >= 0; k--) begin
      sum = {1'b0, start_i} + (IW + 1)'(k);
      if (sum >= (IW + 1)'(N)) begin
        sum = sum - (IW + 1)'(N);
      end
      idx = sum[IW-1:0];
      if (elig_i[idx]) begin
        gnt_valid_o = 1'b1;
        gnt_idx_o   = idx;
      end
    end
  end

endmodule

// File: rtl/fnd_display_scheduler.sv
// rtl/fnd_display_scheduler.sv - APB master sharing the FND display among requesters
// Purpose: keeps FCR[0] in step with disp_en and writes the value of one
//          round-robin-selected requester to FDR, honouring a minimum hold time
//          before a different requester may take over the display.
// Ports:   PCLK/PRESETn           - clock, asynchronous active-low reset
//          req_valid/req_data     - per-requester level request and value
//          req_ack                - 1-cycle pulse when a requester's value reached FDR
//          disp_en                - wanted display enable
//          owner_id/owner_valid   - current display owner, valid once any FDR write completed
//          busy                   - APB transfer (SETUP, ACCESS or ACK) in progress
//          PADDR..PWDATA, PREADY  - APB master interface to the FND slave
module fnd_display_scheduler
  import fnd_pkg::*;
#(
  parameter  int NUM_REQ     = 4,
  parameter  int DATA_W      = 14,
  parameter  int HOLD_CYCLES = 50_000_000,
  parameter  int MAX_VAL     = FND_MAX_VAL,
  localparam int ID_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      PCLK,
  input  logic                      PRESETn,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ack,
  input  logic                      disp_en,
  output logic [ID_W-1:0]           owner_id,
  output logic                      owner_valid,
  output logic                      busy,
  output logic [4:0]                PADDR,
  output logic                      PSEL,
  output logic                      PENABLE,
  output logic                      PWRITE,
  output logic [31:0]               PWDATA,
  input  logic                      PREADY
);

  localparam int              HOLD_W      = $clog2(HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(HOLD_CYCLES - 1);

  fnd_sched_state_e    state_q;
  logic [4:0]          paddr_q;
  logic [31:0]         pwdata_q;
  logic                psel_q, penable_q, pwrite_q;
  logic [NUM_REQ-1:0]  req_ack_q;
  logic [ID_W-1:0]     owner_id_q, job_idx_q;
  logic                owner_valid_q, fcr_shadow_q, job_fdr_q;
  logic [HOLD_W-1:0]   hold_q;

  logic [ID_W-1:0]     rr_start_d;
  logic [NUM_REQ-1:0]  elig_d;
  logic                gnt_valid_d;
  logic [ID_W-1:0]     gnt_idx_d;
  logic [DATA_W-1:0]   sel_data_d, sat_data_d;

  // Round-robin scan starts just after the current owner, so the owner itself
  // is considered last.
  always_comb begin
    rr_start_d = (owner_id_q == ID_W'(NUM_REQ - 1)) ? '0 : owner_id_q + ID_W'(1);
    elig_d     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      elig_d[i] = req_valid[i] &&
                  ((owner_id_q == ID_W'(i)) || !owner_valid_q || (hold_q == '0));
    end
  end

  rr_arbiter #(.N(NUM_REQ)) u_rr_arbiter (
    .start_i     (rr_start_d),
    .elig_i      (elig_d),
    .gnt_valid_o (gnt_valid_d),
    .gnt_idx_o   (gnt_idx_d)
  );

  always_comb begin
    sel_data_d = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx_d == ID_W'(i)) begin
        sel_data_d = req_data[i*DATA_W +: DATA_W];
      end
    end
    sat_data_d = (sel_data_d > DATA_W'(MAX_VAL)) ? DATA_W'(MAX_VAL) : sel_data_d;
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q       <= ST_IDLE;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      req_ack_q     <= '0;
      owner_id_q    <= '0;
      owner_valid_q <= 1'b0;
      fcr_shadow_q  <= 1'b0;
      job_fdr_q     <= 1'b0;
      job_idx_q     <= '0;
      hold_q        <= '0;
    end else begin
      req_ack_q <= '0;
      if (hold_q != '0) begin
        hold_q <= hold_q - HOLD_W'(1);
      end
      case (state_q)
        ST_IDLE: begin
          // A pending display-enable change always goes ahead of any data write.
          if (disp_en != fcr_shadow_q) begin
            paddr_q   <= FND_FCR_ADDR;
            pwdata_q  <= {31'b0, disp_en};
            job_fdr_q <= 1'b0;
            psel_q    <= 1'b1;
            pwrite_q  <= 1'b1;
            state_q   <= ST_SETUP;
          end else if (gnt_valid_d) begin
            paddr_q   <= FND_FDR_ADDR;
            pwdata_q  <= 32'(sat_data_d);
            job_fdr_q <= 1'b1;
            job_idx_q <= gnt_idx_d;
            psel_q    <= 1'b1;
            pwrite_q  <= 1'b1;
            state_q   <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (PREADY) begin
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            state_q   <= ST_ACK;
            if (job_fdr_q) begin
              owner_id_q    <= job_idx_q;
              owner_valid_q <= 1'b1;
              hold_q        <= HOLD_RELOAD;
              req_ack_q     <= NUM_REQ'(1) << job_idx_q;
            end else begin
              fcr_shadow_q <= pwdata_q[0];
            end
          end
        end
        ST_ACK: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign PADDR       = paddr_q;
  assign PWDATA      = pwdata_q;
  assign PSEL        = psel_q;
  assign PENABLE     = penable_q;
  assign PWRITE      = pwrite_q;
  assign req_ack     = req_ack_q;
  assign owner_id    = owner_id_q;
  assign owner_valid = owner_valid_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fnd_display_scheduler.sv
// tb/tb_fnd_display_scheduler.sv - randomized self-checking bench for fnd_display_scheduler
module tb_fnd_display_scheduler;

  localparam int NREQ = 4;
  localparam int DW   = 14;
  localparam int HOLD = 20;

  logic                 PCLK = 1'b0;
  logic                 PRESETn = 1'b0;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ*DW-1:0]   req_data = '0;
  logic [NREQ-1:0]      req_ack;
  logic                 disp_en = 1'b0;
  logic [1:0]           owner_id;
  logic                 owner_valid;
  logic                 busy;
  logic [4:0]           PADDR;
  logic                 PSEL, PENABLE, PWRITE;
  logic [31:0]          PWDATA;
  logic                 PREADY = 1'b0;

  fnd_display_scheduler #(
    .NUM_REQ(NREQ), .DATA_W(DW), .HOLD_CYCLES(HOLD), .MAX_VAL(9999)
  ) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .req_valid(req_valid), .req_data(req_data),
    .req_ack(req_ack), .disp_en(disp_en), .owner_id(owner_id), .owner_valid(owner_valid),
    .busy(busy), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PREADY(PREADY)
  );

  always #5 PCLK = ~PCLK;

  int n_vec = 0;
  int n_bad = 0;

  // Inputs the bench will present for the next clock edge.
  logic [NREQ-1:0] nx_valid = '0;
  int              nx_data[NREQ];
  logic            nx_en = 1'b0;
  int              nx_wait = 1;

  // Reference model: display state plus one scheduled transfer described by
  // the edge it was decided on (t_e) and the edge PREADY completes it (t_c).
  int          cyc;
  bit          act;
  int          t_e, t_c, t_idx;
  bit          t_fdr;
  logic [4:0]  t_addr;
  logic [31:0] t_data;
  int          m_owner, m_last_c;
  bit          m_ovalid, m_fcr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    cyc = 0; act = 0; m_owner = 0; m_ovalid = 0; m_fcr = 0; m_last_c = 0;
  endtask

  // Job choice for a decision made at edge d, using the inputs applied at d.
  task automatic decide(input int d);
    bit found;
    int i;
    found = 0;
    if (nx_en != m_fcr) begin
      found = 1; t_fdr = 0; t_addr = 5'h00; t_data = {31'b0, nx_en};
    end else begin
      for (int k = 1; k <= NREQ; k++) begin
        i = (m_owner + k) % NREQ;
        if (!found && nx_valid[i] &&
            (i == m_owner || !m_ovalid || (d - m_last_c) >= HOLD)) begin
          found = 1; t_fdr = 1; t_idx = i; t_addr = 5'h04;
          t_data = (nx_data[i] > 9999) ? 32'd9999 : 32'(nx_data[i]);
        end
      end
    end
    if (found) begin
      act = 1; t_e = d; t_c = d + 2 + nx_wait;
    end
  endtask

  // Called just after a falling edge: check the state left by the last rising
  // edge, then present inputs for the next one.
  task automatic step();
    bit         e_psel, e_pen, e_busy;
    logic [3:0] e_ack;
    if (act && cyc == t_c) begin
      if (t_fdr) begin
        m_owner = t_idx; m_ovalid = 1; m_last_c = cyc;
      end else begin
        m_fcr = t_data[0];
      end
    end
    e_psel = act && cyc >= t_e && cyc < t_c;
    e_pen  = act && cyc > t_e && cyc < t_c;
    e_busy = act && cyc >= t_e && cyc <= t_c;
    e_ack  = (act && cyc == t_c && t_fdr) ? (4'b0001 << t_idx) : 4'b0000;
    chk("psel", 32'(PSEL), 32'(e_psel));
    chk("penable", 32'(PENABLE), 32'(e_pen));
    chk("pwrite", 32'(PWRITE), 32'(e_psel));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("req_ack", 32'(req_ack), 32'(e_ack));
    chk("owner_valid", 32'(owner_valid), 32'(m_ovalid));
    chk("owner_id", 32'(owner_id), 32'(m_owner));
    if (e_psel) begin
      chk("paddr", 32'(PADDR), 32'(t_addr));
      chk("pwdata", PWDATA, t_data);
    end
    if (act && cyc > t_c) act = 0;
    req_valid = nx_valid;
    for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = nx_data[i][DW-1:0];
    disp_en = nx_en;
    if (!act) decide(cyc + 1);
    PREADY = act && (cyc + 1 == t_c);
    @(posedge PCLK);
    cyc++;
    @(negedge PCLK);
  endtask

  task automatic steps(input int n);
    for (int s = 0; s < n; s++) step();
  endtask

  task automatic rand_steps(input int n);
    for (int s = 0; s < n; s++) begin
      for (int i = 0; i < NREQ; i++) begin
        if ($urandom_range(0, 7) == 0) nx_valid[i] = ~nx_valid[i];
        if ($urandom_range(0, 3) == 0) nx_data[i] = int'($urandom_range(0, 16383));
      end
      if ($urandom_range(0, 59) == 0) nx_en = ~nx_en;
      nx_wait = int'($urandom_range(1, 4));
      step();
    end
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) nx_data[i] = 0;
    model_reset();
    repeat (3) @(negedge PCLK);
    PRESETn = 1'b1;

    // display enable with nothing requested
    nx_en = 1'b1; nx_wait = 1;
    steps(10);
    // requester 2 shows 1234
    nx_valid = 4'b0100; nx_data[2] = 1234;
    steps(8);
    // requesters 0 and 3 wait out the hold time of owner 2
    nx_valid = 4'b1001; nx_data[0] = 111; nx_data[3] = 333;
    steps(40);
    nx_valid = 4'b0001;
    steps(30);
    // saturation, then an owner refresh inside its hold time
    nx_valid = 4'b0010; nx_data[1] = 16383;
    steps(30);
    nx_data[1] = 5678; nx_wait = 2;
    steps(6);
    nx_valid = 4'b0000;
    steps(4);
    // disable and a data request in the same cycle, slow slave
    nx_en = 1'b0; nx_valid = 4'b0001; nx_wait = 10;
    steps(40);

    rand_steps(1500);

    // reset while the slave holds ACCESS
    nx_en = ~nx_en; nx_wait = 8;
    for (int s = 0; s < 40 && !(act && cyc > t_e && cyc < t_c); s++) step();
    chk("reach_access", 32'(act && cyc > t_e && cyc < t_c), 32'd1);
    #2 PRESETn = 1'b0;
    #1;
    chk("rst_psel", 32'(PSEL), 32'd0);
    chk("rst_penable", 32'(PENABLE), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_req_ack", 32'(req_ack), 32'd0);
    chk("rst_owner_valid", 32'(owner_valid), 32'd0);
    PREADY = 1'b0;
    @(negedge PCLK);
    PRESETn = 1'b1;
    model_reset();
    rand_steps(400);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
